stage_controller: RTL

STAGE_CONTROLLER -- requirements
Module: stage_controller

---
 rtl/stage_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/stage_controller.sv
// stage_controller: multi-cycle instruction sequencer.
// Walks each instruction through FETCH, DECODE, optional MEMORY and REGISTER_UPDATE,
// then PC_UPDATE, and tracks the program counter and the retired-instruction count.
// Optional feature: define MEM_TIMEOUT_EN to add a memory-request watchdog that
// parks the controller in FAULT when a request waits MEM_TIMEOUT cycles.
module stage_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned STAGE_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4:0]             instr_type,
    input  logic                   jump_taken,
    input  logic [31:0]            jump_target,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_is_write,
    output logic                   instr_latch_en,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic [31:0]            pc,
    output logic                   halted,
    output logic                   fault,
    output logic [31:0]            retired_count
);

    // Instruction type codes; code 0 and every unlisted code behave as a NOP.
    localparam logic [4:0] INSTR_ALU_OP         = 5'd1;
    localparam logic [4:0] INSTR_LOAD_IMMEDIATE = 5'd2;
    localparam logic [4:0] INSTR_LOAD           = 5'd3;
    localparam logic [4:0] INSTR_STORE          = 5'd4;
    localparam logic [4:0] INSTR_JUMP           = 5'd5;
    localparam logic [4:0] INSTR_HALT           = 5'd6;

    // Stage codes presented to register_file_control.
    localparam logic [STAGE_WIDTH-1:0] STAGE_HALTED          = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_FETCH           = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_DECODE          = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEMORY          = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_REGISTER_UPDATE = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] STAGE_PC_UPDATE       = STAGE_WIDTH'(5);
    localparam logic [STAGE_WIDTH-1:0] STAGE_FAULT           = STAGE_WIDTH'(6);

    typedef enum logic [2:0] {
        StHalted,
        StFetch,
        StDecode,
        StMemory,
        StRegUpdate,
        StPcUpdate,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [4:0]  type_q, type_d;
    logic        tmo_hit;

`ifdef MEM_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
    assign tmo_hit = ((tmo_q + 32'd1) >= MEM_TIMEOUT);
`else
    logic unused_tmo;

    // Without the watchdog a request waits indefinitely.
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^MEM_TIMEOUT;
`endif

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        retired_d      = retired_q;
        type_d         = type_q;
        mem_req        = 1'b0;
        mem_is_write   = 1'b0;
        instr_latch_en = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;

        unique case (state_q)
            StHalted: begin
                halted = 1'b1;
                if (start) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    instr_latch_en = 1'b1;
                    state_d        = StDecode;
                end else if (tmo_hit) begin
                    state_d = StFault;
                end
            end

            StDecode: begin
                // The live type is both captured and used for dispatch this cycle.
                type_d = instr_type;
                if (instr_type == INSTR_ALU_OP || instr_type == INSTR_LOAD_IMMEDIATE) begin
                    state_d = StRegUpdate;
                end else if (instr_type == INSTR_LOAD || instr_type == INSTR_STORE) begin
                    state_d = StMemory;
                end else begin
                    state_d = StPcUpdate;
                end
            end

            StMemory: begin
                mem_req      = 1'b1;
                mem_is_write = (type_q == INSTR_STORE);
                if (mem_ready) begin
                    state_d = (type_q == INSTR_LOAD) ? StRegUpdate : StPcUpdate;
                end else if (tmo_hit) begin
                    state_d = StFault;
                end
            end

            StRegUpdate: begin
                state_d = StPcUpdate;
            end

            StPcUpdate: begin
                // Jump inputs are only looked at here; both counters wrap silently.
                if (type_q == INSTR_JUMP && jump_taken) begin
                    pc_d = jump_target;
                end else begin
                    pc_d = pc_q + 32'(PC_STEP);
                end
                retired_d = retired_q + 32'd1;
                state_d   = (type_q == INSTR_HALT) ? StHalted : StFetch;
            end

            StFault: begin
`ifdef MEM_TIMEOUT_EN
                fault = 1'b1;
`endif
                // Sticky until reset; start has no effect here.
                state_d = StFault;
            end

            default: begin
                state_d = StHalted;
            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog count: restarts on entry to a requesting state, counts unanswered cycles.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d == StFetch || state_d == StMemory) && state_d != state_q) begin
            tmo_d = '0;
        end else if (mem_req && !mem_ready) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Architectural state; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHalted;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            type_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            type_q    <= type_d;
        end
    end

    // Map internal state onto the published stage codes.
    always_comb begin
        stage = STAGE_HALTED;
        unique case (state_q)
            StHalted:    stage = STAGE_HALTED;
            StFetch:     stage = STAGE_FETCH;
            StDecode:    stage = STAGE_DECODE;
            StMemory:    stage = STAGE_MEMORY;
            StRegUpdate: stage = STAGE_REGISTER_UPDATE;
            StPcUpdate:  stage = STAGE_PC_UPDATE;
            StFault:     stage = STAGE_FAULT;
            default:     stage = STAGE_HALTED;
        endcase
    end

    assign pc            = pc_q;
    assign retired_count = retired_q;

endmodule
